// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage of the 8-bit core.
//   - default datapath, register-number and opcode widths
//   - FSM state encodings (IDLE, MUL, WB)
//   - opcode enumeration (0..8 defined, 9..15 illegal)
package exec_pkg;

    localparam int unsigned EXEC_WIDTH  = 8;
    localparam int unsigned EXEC_REG_AW = 3;
    localparam int unsigned EXEC_OPC_W  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

    typedef enum logic [EXEC_OPC_W-1:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_MOV = 4'd7,
        OP_MUL = 4'd8
    } opcode_e;

endpackage

// File: rtl/execute_unit_shift_add_mul.sv
// shift_add_mul: iterative unsigned WIDTH x WIDTH shift-add multiplier.
// Only compiled when EXEC_MUL_EN is defined.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   start      load operands and begin (ignored while busy by the caller's FSM)
//   a, b       multiplicand / multiplier, sampled when start is high
//   busy       iterations remaining
//   done       high during the final iteration; product valid the cycle after
//   product    2*WIDTH-bit accumulated product
`ifdef EXEC_MUL_EN
module shift_add_mul
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH = EXEC_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // One multiplier bit per cycle, LSB first; multiplicand shifts left alongside.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy    = (cnt_q != '0);
    assign done    = (cnt_q == CNT_W'(1));
    assign product = acc_q;

endmodule
`endif

// File: rtl/execute_unit.sv
// execute_unit: execute stage of the 8-bit core. Single-cycle ALU ops and an
// optional 8-cycle shift-add MUL, producing register-file write-back signals.
// Configuration macro: EXEC_MUL_EN (defined: MUL supported; undefined: opcode 8
// is illegal and wb_mul_high is tied to zero).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   issue_valid/issue_ready  issue handshake; ready only in IDLE
//   opcode, op_a, op_b       operation and operands, sampled on acceptance
//   dest_num                 destination register number
//   wb_en                    one-cycle write-back strobe
//   wb_num, wb_data          write-back register number and data (MUL low byte)
//   wb_mul_high              MUL high byte, zero for other ops
//   flag_z, flag_c           flags of the last written-back result
//   illegal                  one-cycle pulse when an illegal opcode is accepted
module execute_unit
    import exec_pkg::*;
#(
    parameter int unsigned WIDTH  = EXEC_WIDTH,
    parameter int unsigned REG_AW = EXEC_REG_AW,
    parameter int unsigned OPC_W  = EXEC_OPC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [OPC_W-1:0]  opcode,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [REG_AW-1:0] dest_num,
    output logic              wb_en,
    output logic [REG_AW-1:0] wb_num,
    output logic [WIDTH-1:0]  wb_data,
    output logic [WIDTH-1:0]  wb_mul_high,
    output logic              flag_z,
    output logic              flag_c,
    output logic              illegal
);

    logic [1:0]        state_q, state_d;
    logic              wb_en_q, wb_en_d;
    logic              illegal_q, illegal_d;
    logic [REG_AW-1:0] wb_num_q, wb_num_d;
    logic [WIDTH-1:0]  wb_data_q, wb_data_d;
    logic              flag_z_q, flag_z_d;
    logic              flag_c_q, flag_c_d;

    logic                  accept;
    logic                  is_alu;
    logic [EXEC_OPC_W-1:0] opc;
    logic [WIDTH-1:0]      alu_res;
    logic                  alu_c;
    logic [WIDTH:0]        ext;
    logic [2:0]            sh;

`ifdef EXEC_MUL_EN
    logic                  is_mul;
    logic                  mul_start;
    logic                  mul_busy;
    logic                  mul_done;
    logic [2*WIDTH-1:0]    mul_product;
    logic [REG_AW-1:0]     mul_dest_q, mul_dest_d;
    logic [WIDTH-1:0]      wb_mul_high_q, wb_mul_high_d;

    shift_add_mul #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    assign is_mul      = (opcode == OPC_W'(OP_MUL));
    assign issue_ready = (state_q == ST_IDLE) && !mul_busy;
    assign wb_mul_high = wb_mul_high_q;
`else
    assign issue_ready = (state_q == ST_IDLE);
    assign wb_mul_high = '0;
`endif

    assign accept = issue_valid && issue_ready;
    // Range check uses the full opcode; the ALU decode only needs the low bits.
    assign is_alu = (opcode < OPC_W'(OP_MUL));
    assign opc    = EXEC_OPC_W'(opcode);
    assign sh     = op_b[2:0];

    // Extended-width intermediates carry the carry/borrow/shifted-out bit in
    // ext[WIDTH] (ADD/SUB/SHL) or ext[0] (SHR).
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        ext     = '0;
        case (opc)
            OP_ADD: begin
                ext     = {1'b0, op_a} + {1'b0, op_b};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_SUB: begin
                ext     = {1'b0, op_a} - {1'b0, op_b};
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_SHL: begin
                ext     = {1'b0, op_a} << sh;
                alu_res = ext[WIDTH-1:0];
                alu_c   = ext[WIDTH];
            end
            OP_SHR: begin
                ext     = {op_a, 1'b0} >> sh;
                alu_res = ext[WIDTH:1];
                alu_c   = ext[0];
            end
            OP_MOV: alu_res = op_a;
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wb_en_d   = 1'b0;
        illegal_d = 1'b0;
        wb_num_d  = wb_num_q;
        wb_data_d = wb_data_q;
        flag_z_d  = flag_z_q;
        flag_c_d  = flag_c_q;
`ifdef EXEC_MUL_EN
        mul_start     = 1'b0;
        mul_dest_d    = mul_dest_q;
        wb_mul_high_d = wb_mul_high_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_alu) begin
                        wb_en_d   = 1'b1;
                        wb_num_d  = dest_num;
                        wb_data_d = alu_res;
                        flag_z_d  = (alu_res == '0);
                        flag_c_d  = alu_c;
`ifdef EXEC_MUL_EN
                        wb_mul_high_d = '0;
                    end else if (is_mul) begin
                        mul_start  = 1'b1;
                        mul_dest_d = dest_num;
                        state_d    = ST_MUL;
`endif
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
`ifdef EXEC_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                wb_en_d       = 1'b1;
                wb_num_d      = mul_dest_q;
                wb_data_d     = mul_product[WIDTH-1:0];
                wb_mul_high_d = mul_product[2*WIDTH-1:WIDTH];
                flag_z_d      = (mul_product == '0);
                flag_c_d      = (mul_product[2*WIDTH-1:WIDTH] != '0);
                state_d       = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wb_en_q   <= 1'b0;
            illegal_q <= 1'b0;
            wb_num_q  <= '0;
            wb_data_q <= '0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wb_en_q   <= wb_en_d;
            illegal_q <= illegal_d;
            wb_num_q  <= wb_num_d;
            wb_data_q <= wb_data_d;
            flag_z_q  <= flag_z_d;
            flag_c_q  <= flag_c_d;
        end
    end

`ifdef EXEC_MUL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_dest_q    <= '0;
            wb_mul_high_q <= '0;
        end else begin
            mul_dest_q    <= mul_dest_d;
            wb_mul_high_q <= wb_mul_high_d;
        end
    end
`endif

    assign wb_en   = wb_en_q;
    assign illegal = illegal_q;
    assign wb_num  = wb_num_q;
    assign wb_data = wb_data_q;
    assign flag_z  = flag_z_q;
    assign flag_c  = flag_c_q;

endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: constant vector table, hand-written
// multi-cycle sequences and randomized ops against an arithmetic model.
module tb_execute_unit;

`ifdef EXEC_MUL_EN
    localparam bit MUL_BUILD = 1'b1;
`else
    localparam bit MUL_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic       issue_ready;
    logic [3:0] opcode;
    logic [7:0] op_a, op_b;
    logic [2:0] dest_num;
    logic       wb_en;
    logic [2:0] wb_num;
    logic [7:0] wb_data, wb_mul_high;
    logic       flag_z, flag_c, illegal;

    execute_unit dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .opcode      (opcode),
        .op_a        (op_a),
        .op_b        (op_b),
        .dest_num    (dest_num),
        .wb_en       (wb_en),
        .wb_num      (wb_num),
        .wb_data     (wb_data),
        .wb_mul_high (wb_mul_high),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Last written-back values; these must hold across illegal ops and idle cycles.
    logic [7:0] e_data, e_high;
    logic [2:0] e_num;
    logic       e_z, e_c;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] d;
        bit         ill;
        logic [7:0] data;
        bit         c;
        bit         z;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void model(input int op, input int a, input int b,
                                  output int res, output int hi, output bit c,
                                  output bit z, output bit legal, output bit ism);
        int n;
        int p;
        n = b % 8;
        res = 0; hi = 0; c = 1'b0; legal = 1'b1; ism = 1'b0;
        case (op)
            0: begin p = a + b; res = p % 256; c = (p > 255); end
            1: begin res = (a - b + 256) % 256; c = (a < b); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin p = a * (1 << n); res = p % 256; c = (n != 0) && ((p / 256) % 2 == 1); end
            6: begin res = a / (1 << n); c = (n != 0) && ((a / (1 << (n - 1))) % 2 == 1); end
            7: res = a;
            8: begin
                if (MUL_BUILD) begin
                    p = a * b; res = p % 256; hi = p / 256; c = (hi != 0); ism = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
        z = ism ? ((a * b) == 0) : (res == 0);
    endfunction

    task automatic chk_outputs(input string tag, input bit x_wb, input bit x_ill);
        chk({tag, "_wb_en"},   wb_en, x_wb);
        chk({tag, "_illegal"}, illegal, x_ill);
        chk({tag, "_wb_num"},  wb_num, e_num);
        chk({tag, "_wb_data"}, wb_data, e_data);
        chk({tag, "_mul_hi"},  wb_mul_high, e_high);
        chk({tag, "_flag_z"},  flag_z, e_z);
        chk({tag, "_flag_c"},  flag_c, e_c);
        chk({tag, "_ready"},   issue_ready, 1);
    endtask

    // Issue one op and check its result; returns at accept/write-back edge + 1.
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] d, input bit legal, input bit is_mul,
                         input logic [7:0] x_data, input logic [7:0] x_high,
                         input bit x_c, input bit x_z, input string tag);
        int waited;
        int rdy_hi;
        int early;
        waited = 0;
        @(negedge clk);
        issue_valid = 1'b1; opcode = op; op_a = a; op_b = b; dest_num = d;
        while (!issue_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!issue_ready) begin
            chk({tag, "_ready_timeout"}, 0, 1);
            issue_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        // Scramble inputs: the unit must have captured everything at acceptance.
        issue_valid = 1'b0;
        opcode = 4'($urandom); op_a = 8'($urandom); op_b = 8'($urandom); dest_num = 3'($urandom);
        if (!legal) begin
            chk_outputs({tag, "_ill"}, 1'b0, 1'b1);
        end else if (is_mul) begin
            rdy_hi = 0;
            early  = 0;
            for (int k = 0; k < 9; k++) begin
                if (k > 0) begin
                    @(posedge clk);
                    #1;
                end
                if (issue_ready) rdy_hi++;
                if (wb_en) early++;
            end
            chk({tag, "_ready_low_9"}, rdy_hi, 0);
            chk({tag, "_no_early_wb"}, early, 0);
            @(posedge clk);
            #1;
            e_num = d; e_data = x_data; e_high = x_high; e_c = x_c; e_z = x_z;
            chk_outputs(tag, 1'b1, 1'b0);
        end else begin
            e_num = d; e_data = x_data; e_high = 8'h00; e_c = x_c; e_z = x_z;
            chk_outputs(tag, 1'b1, 1'b0);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        e_num = '0; e_data = '0; e_high = '0; e_z = 1'b0; e_c = 1'b0;
        chk({tag, "_wb_en"},   wb_en, 0);
        chk({tag, "_illegal"}, illegal, 0);
        chk({tag, "_wb_num"},  wb_num, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_mul_hi"},  wb_mul_high, 0);
        chk({tag, "_flag_z"},  flag_z, 0);
        chk({tag, "_flag_c"},  flag_c, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int res, hi;
        bit c, z, legal, ism;
        logic [3:0] r_op;
        logic [7:0] r_a, r_b;
        logic [2:0] r_d;
        int cnt;

        rst = 1'b1; issue_valid = 1'b0; opcode = '0; op_a = '0; op_b = '0; dest_num = '0;

        //               op     a      b     d    ill  data   c  z
        vecs.push_back('{4'h0, 8'hFF, 8'h01, 3'd1, 0, 8'h00, 1, 1});
        vecs.push_back('{4'hC, 8'h55, 8'h66, 3'd3, 1, 8'h00, 0, 0});
        vecs.push_back('{4'h0, 8'h12, 8'h34, 3'd2, 0, 8'h46, 0, 0});
        vecs.push_back('{4'h1, 8'h03, 8'h05, 3'd6, 0, 8'hFE, 1, 0});
        vecs.push_back('{4'h5, 8'h81, 8'h01, 3'd7, 0, 8'h02, 1, 0});
        vecs.push_back('{4'h6, 8'h01, 8'h01, 3'd0, 0, 8'h00, 1, 1});
        vecs.push_back('{4'h1, 8'h05, 8'h05, 3'd1, 0, 8'h00, 0, 1});
        vecs.push_back('{4'h2, 8'hF0, 8'h3C, 3'd2, 0, 8'h30, 0, 0});
        vecs.push_back('{4'h3, 8'hF0, 8'h0F, 3'd3, 0, 8'hFF, 0, 0});
        vecs.push_back('{4'h4, 8'hAA, 8'hAA, 3'd4, 0, 8'h00, 0, 1});
        vecs.push_back('{4'h5, 8'h03, 8'h07, 3'd5, 0, 8'h80, 1, 0});
        vecs.push_back('{4'h5, 8'h40, 8'h09, 3'd6, 0, 8'h80, 0, 0});
        vecs.push_back('{4'h6, 8'h80, 8'h00, 3'd7, 0, 8'h80, 0, 0});
        vecs.push_back('{4'h6, 8'h85, 8'h03, 3'd0, 0, 8'h10, 1, 0});
        vecs.push_back('{4'hF, 8'h00, 8'h00, 3'd2, 1, 8'h00, 0, 0});
        vecs.push_back('{4'h7, 8'h5A, 8'h33, 3'd1, 0, 8'h5A, 0, 0});
        vecs.push_back('{4'h7, 8'h00, 8'hFF, 3'd3, 0, 8'h00, 0, 1});

        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", issue_ready, 1);

        // Table: issued back-to-back, one accept per clock.
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].d, !vecs[i].ill, 1'b0,
                  vecs[i].data, 8'h00, vecs[i].c, vecs[i].z, $sformatf("vec%0d", i));
        end
        @(posedge clk);
        #1;
        chk("idle_after_table_wb_en", wb_en, 0);

`ifdef EXEC_MUL_EN
        do_op(4'h8, 8'hFF, 8'hFF, 3'd5, 1'b1, 1'b1, 8'h01, 8'hFE, 1'b1, 1'b0, "mul_ff_ff");
        do_op(4'h8, 8'h00, 8'h9C, 3'd2, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, "mul_zero");
        do_op(4'h8, 8'h10, 8'h08, 3'd4, 1'b1, 1'b1, 8'h80, 8'h00, 1'b0, 1'b0, "mul_lo_only");
        do_op(4'h0, 8'h01, 8'h01, 3'd6, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, "add_after_mul");

        // Reset during the 4th MUL cycle: aborted, no write-back.
        do_op(4'h7, 8'hA5, 8'h00, 3'd7, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b0, 1'b0, "mov_pre_rst");
        @(negedge clk);
        issue_valid = 1'b1; opcode = 4'h8; op_a = 8'hFF; op_b = 8'hFF; dest_num = 3'd5;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_values("rst_mid_mul");
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (wb_en) cnt++;
        end
        chk("rst_mid_mul_no_wb", cnt, 0);
        chk("rst_mid_mul_ready", issue_ready, 1);
`else
        // MUL is illegal in this build and must never stall the unit.
        do_op(4'h8, 8'h02, 8'h03, 3'd4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, "mul_disabled");
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (!issue_ready || wb_en) cnt++;
        end
        chk("mul_disabled_stays_ready", cnt, 0);
`endif

        // Randomized ops against the arithmetic model.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) r_op = 4'($urandom_range(9, 15));
            else                           r_op = 4'($urandom_range(0, 8));
            r_a = 8'($urandom);
            r_b = 8'($urandom);
            r_d = 3'($urandom);
            if ($urandom_range(0, 5) == 0) r_b = 8'h00;
            model(int'(r_op), int'(r_a), int'(r_b), res, hi, c, z, legal, ism);
            do_op(r_op, r_a, r_b, r_d, legal, ism, 8'(res), 8'(hi), c, z, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
                chk_outputs($sformatf("rnd%0d_gap", i), 1'b0, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
